mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
Iterative multiply/divide sequencer for the EX stage. Implements the RV32M ops MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Operands come from the forwarded EX operands, after the forwarding muxes.
- Holds the pipeline via a stall request while iterating.
- Returns a 32-bit result alongside the ALU result for the EX/MEM register.

Parameters:
XLEN, 32, operand/result width
ITER, 32, iterations per operation (must equal XLEN)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start_ex  input  1  EX holds a valid M-extension op
MDUCode_ex  input  3  funct3 of the op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
A_ex  input  XLEN  rs1 operand, post-forwarding
B_ex  input  XLEN  rs2 operand, post-forwarding
flush_ex  input  1  kill the in-flight op (branch/jump redirect)
MDUResult_ex  output  XLEN  result, valid when done_ex=1
done_ex  output  1  one-cycle result-valid pulse
busy_ex  output  1  state != IDLE
stall_req  output  1  freeze PC, IF/ID and ID/EX

Behaviour:
- Single clock domain: clk. reset is synchronous, active-high.
- Reset values: state=IDLE, MDUResult_ex=0, done_ex=0, busy_ex=0; internal accumulator, operand and counter registers all 0.
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE -> CALC when start_ex=1 and flush_ex=0:
  - latch op code;
  - latch |A_ex| and |B_ex| (sign-magnitude per op signedness);
  - latch sign flags;
  - clear the accumulator;
  - counter=0.
- IDLE -> DONE (short cut) on a divide op with B_ex==0:
  - DIV/DIVU result = all ones;
  - REM/REMU result = A_ex.
- IDLE -> DONE (short cut) on DIV/REM with A_ex==0x80000000 and B_ex==0xFFFFFFFF:
  - DIV result = 0x80000000;
  - REM result = 0.
- CALC, one iteration per cycle:
  - multiply: shift-add on a 2*XLEN product register;
  - divide: restoring, one shift-subtract;
  - counter increments each cycle; leave CALC after counter reaches ITER-1.
- CALC -> FIXUP after ITER cycles.
- FIXUP:
  - negate the product if the operand signs differ (MULH/MULHSU);
  - negate the quotient if signs differ (DIV);
  - remainder takes the dividend's sign (REM);
  - select low/high product half or quotient/remainder into MDUResult_ex.
- FIXUP -> DONE.
- DONE: done_ex=1 for exactly one cycle, then -> IDLE. MDUResult_ex holds its value until the next DONE.
- Latency: start accepted at cycle 0; done_ex at cycle ITER+2 (34). Short-cut ops: done_ex at cycle 1.
- stall_req = (state==IDLE & start_ex & ~flush_ex) | (state==CALC) | (state==FIXUP).
  - stall_req is low in DONE, so the pipeline advances on the same cycle the result is consumed.
  - stall_req is combinational from start_ex in IDLE.
- flush_ex in any state: next state IDLE; done_ex is not asserted; MDUResult_ex is unchanged.
- flush_ex and start_ex in the same cycle: flush wins; the op is not accepted.
- start_ex while busy_ex=1 is ignored. The pipeline is stalled, so start_ex stays high for the same instruction; after DONE the sequencer must not re-accept it.
  - Mechanism: a one-cycle accept-block flag set in DONE and cleared in IDLE.
- reset mid-operation: immediate return to reset values on the next edge.
- All arithmetic is modulo 2^XLEN. MULHSU treats A_ex as signed and B_ex as unsigned.

Optional Feature:
MDU_FASTMUL_EN
- Defined: multiply ops take a single-cycle combinational 32x32 product, IDLE -> FIXUP directly; done_ex at cycle 2 after start. Divides are unchanged.
- Undefined: all ops use the iterative CALC path; no hardware multiplier is inferred.

Decomposition:
- Shared package:
  - MDUCode encodings (MDU_MUL..MDU_REMU);
  - FSM state encoding;
  - XLEN;
  - the constants DIV0_QUOT (all ones) and INT_MIN (0x80000000).
- One sub-module, mdu_divstep: combinational single restoring-division step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.
- The FSM, counter and multiply path stay in mdu_seq.

Test Plan:
1. MUL A=7, B=-3 (0xFFFFFFFD) -> stall_req high 34 cycles; done_ex at cycle 34; MDUResult_ex=0xFFFFFFEB.
2. MULHU A=0xFFFFFFFF, B=0xFFFFFFFF -> MDUResult_ex=0xFFFFFFFE. MULH with the same operands -> 0x00000000.
3. DIV A=-7, B=2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). DIVU A=100, B=7 -> 14. REMU with the same operands -> 2.
4. DIVU A=5, B=0 -> done_ex at cycle 1 with 0xFFFFFFFF. REM A=5, B=0 -> 5. DIV A=0x80000000, B=-1 -> 0x80000000.
5. Start DIV, assert flush_ex at cycle 10 -> busy_ex=0 at cycle 11; no done_ex pulse; new start at cycle 12 completes correctly.
6. start_ex held high through the full op -> exactly one done_ex pulse. reset asserted at cycle 5 -> all outputs 0 next edge.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// op encodings (funct3), FSM states and the divide corner-case constants.
package mdu_seq_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_code_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mdu_state_e;

    // Quotient returned for a divide by zero
    localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
    // Most negative value; INT_MIN / -1 overflows back to itself
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/mdu_seq_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_divstep #(
    parameter int XLEN = mdu_seq_pkg::XLEN
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            dvd_bit,
    output logic [XLEN-1:0] rem_out,
    output logic            quot_bit
);

    logic [XLEN:0] shifted;

    // Trial subtract; the kept remainder is always below the divisor, so the
    // low XLEN bits of the modulo difference are exact.
    always_comb begin
        shifted  = {rem_in, dvd_bit};
        quot_bit = (shifted >= {1'b0, divisor});
        rem_out  = quot_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Multiplies use shift-add on a 2*XLEN product register, divides use a
// restoring shift-subtract; both run on sign magnitudes and are fixed up at
// the end. Build option: define MDU_FASTMUL_EN to compute multiplies with a
// single-cycle combinational product (IDLE -> FIXUP), divides unchanged.
module mdu_seq #(
    parameter int XLEN = mdu_seq_pkg::XLEN,
    parameter int ITER = mdu_seq_pkg::ITER
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_ex,
    input  logic [2:0]      MDUCode_ex,
    input  logic [XLEN-1:0] A_ex,
    input  logic [XLEN-1:0] B_ex,
    input  logic            flush_ex,
    output logic [XLEN-1:0] MDUResult_ex,
    output logic            done_ex,
    output logic            busy_ex,
    output logic            stall_req
);

    import mdu_seq_pkg::*;

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    mdu_state_e        state_q;
    mdu_code_e         code_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic [XLEN-1:0]   op_q;        // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q;       // product, or {remainder, dividend/quotient}
    logic [CNT_W-1:0]  cnt_q;
    logic              accept_blk_q;

    mdu_code_e         code_in;
    logic              is_div_in;
    logic              neg_a_in;
    logic              neg_b_in;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   short_res;
    logic              accept;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   step_rem;
    logic              step_qbit;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    // Decode the incoming op: signedness, magnitudes and divide short cuts
    always_comb begin
        code_in   = mdu_code_e'(MDUCode_ex);
        is_div_in = MDUCode_ex[2];
        neg_a_in  = A_ex[XLEN-1] && (code_in == MDU_MULH || code_in == MDU_MULHSU ||
                                     code_in == MDU_DIV  || code_in == MDU_REM);
        neg_b_in  = B_ex[XLEN-1] && (code_in == MDU_MULH || code_in == MDU_DIV ||
                                     code_in == MDU_REM);
        a_mag     = cond_neg(A_ex, neg_a_in);
        b_mag     = cond_neg(B_ex, neg_b_in);
        div_zero  = is_div_in && (B_ex == '0);
        div_ovf   = (code_in == MDU_DIV || code_in == MDU_REM) &&
                    (A_ex == INT_MIN) && (B_ex == {XLEN{1'b1}});
        // bit 1 of a divide code selects the remainder
        if (div_zero)
            short_res = MDUCode_ex[1] ? A_ex : DIV0_QUOT;
        else
            short_res = MDUCode_ex[1] ? '0 : INT_MIN;
        accept    = (state_q == IDLE) && start_ex && !flush_ex && !accept_blk_q;
    end

    mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .rem_in   (acc_q[2*XLEN-1:XLEN]),
        .divisor  (op_q),
        .dvd_bit  (acc_q[XLEN-1]),
        .rem_out  (step_rem),
        .quot_bit (step_qbit)
    );

    // Next accumulator value for one multiply or divide iteration
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_next = {step_rem, acc_q[XLEN-2:0], step_qbit};
    end

    // Sign fixup and result selection applied in FIXUP
    always_comb begin
        prod_fix = cond_neg2(acc_q, neg_a_q ^ neg_b_q);
        quot_fix = cond_neg(acc_q[XLEN-1:0], neg_a_q ^ neg_b_q);
        rem_fix  = cond_neg(acc_q[2*XLEN-1:XLEN], neg_a_q);
        case (code_q)
            MDU_MUL:                        fix_result = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              fix_result = quot_fix;
            default:                        fix_result = rem_fix;
        endcase
    end

    // Stall from the accepting cycle until the result is ready
    always_comb begin
        stall_req = accept || (state_q == CALC) || (state_q == FIXUP);
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            code_q       <= MDU_MUL;
            neg_a_q      <= 1'b0;
            neg_b_q      <= 1'b0;
            op_q         <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            accept_blk_q <= 1'b0;
            MDUResult_ex <= '0;
            done_ex      <= 1'b0;
            busy_ex      <= 1'b0;
        end else begin
            done_ex <= 1'b0;
            if (flush_ex) begin
                state_q      <= IDLE;
                busy_ex      <= 1'b0;
                accept_blk_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        accept_blk_q <= 1'b0;
                        if (accept) begin
                            code_q  <= code_in;
                            neg_a_q <= neg_a_in;
                            neg_b_q <= neg_b_in;
                            op_q    <= is_div_in ? b_mag : a_mag;
                            acc_q   <= {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
                            cnt_q   <= '0;
                            busy_ex <= 1'b1;
                            if (div_zero || div_ovf) begin
                                MDUResult_ex <= short_res;
                                done_ex      <= 1'b1;
                                state_q      <= DONE;
`ifdef MDU_FASTMUL_EN
                            end else if (!is_div_in) begin
                                acc_q   <= {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
                                state_q <= FIXUP;
`endif
                            end else begin
                                state_q <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        acc_q <= code_q[2] ? div_next : mul_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST)
                            state_q <= FIXUP;
                    end
                    FIXUP: begin
                        MDUResult_ex <= fix_result;
                        done_ex      <= 1'b1;
                        state_q      <= DONE;
                    end
                    default: begin
                        state_q      <= IDLE;
                        busy_ex      <= 1'b0;
                        accept_blk_q <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: table of RV32M ops with hand-computed results
// and latencies, plus sequences for flush, held start and mid-op reset.
module tb_mdu_seq;

    localparam logic [2:0] C_MUL    = 3'd0;
    localparam logic [2:0] C_MULH   = 3'd1;
    localparam logic [2:0] C_MULHSU = 3'd2;
    localparam logic [2:0] C_MULHU  = 3'd3;
    localparam logic [2:0] C_DIV    = 3'd4;
    localparam logic [2:0] C_DIVU   = 3'd5;
    localparam logic [2:0] C_REM    = 3'd6;
    localparam logic [2:0] C_REMU   = 3'd7;

    localparam int LONG_LAT  = 34;
    localparam int SHORT_LAT = 1;
`ifdef MDU_FASTMUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    typedef struct {
        logic [2:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 19;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_ex;
    logic [2:0]  MDUCode_ex;
    logic [31:0] A_ex;
    logic [31:0] B_ex;
    logic        flush_ex;
    logic [31:0] MDUResult_ex;
    logic        done_ex;
    logic        busy_ex;
    logic        stall_req;

    int total = 0;
    int bad   = 0;

    vec_t vecs[NVEC];

    mdu_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start_ex     (start_ex),
        .MDUCode_ex   (MDUCode_ex),
        .A_ex         (A_ex),
        .B_ex         (B_ex),
        .flush_ex     (flush_ex),
        .MDUResult_ex (MDUResult_ex),
        .done_ex      (done_ex),
        .busy_ex      (busy_ex),
        .stall_req    (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge with the DUT idle; start stays high
    // until done_ex is seen, as a stalled pipeline would hold it.
    task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls);
        start_ex   = 1'b1;
        MDUCode_ex = code;
        A_ex       = a;
        B_ex       = b;
        lat        = -1;
        stalls     = 0;
        res        = '0;
        for (int c = 0; c < 60 && lat < 0; c++) begin
            @(negedge clk);
            if (stall_req) stalls++;
            if (done_ex) begin
                lat = c;
                res = MDUResult_ex;
            end
            @(posedge clk); #1;
        end
        start_ex = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        int          stalls;
        int          pulses;
        logic [31:0] last_exp;

        vecs[0]  = '{C_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
        vecs[1]  = '{C_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
        vecs[2]  = '{C_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT};
        vecs[3]  = '{C_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT};
        vecs[4]  = '{C_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
        vecs[5]  = '{C_MUL,    32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT};
        vecs[6]  = '{C_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LONG_LAT};
        vecs[7]  = '{C_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LONG_LAT};
        vecs[8]  = '{C_DIVU,   32'd100,      32'd7,        32'd14,       LONG_LAT};
        vecs[9]  = '{C_REMU,   32'd100,      32'd7,        32'd2,        LONG_LAT};
        vecs[10] = '{C_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LONG_LAT};
        vecs[11] = '{C_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        LONG_LAT};
        vecs[12] = '{C_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, LONG_LAT};
        vecs[13] = '{C_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        LONG_LAT};
        vecs[14] = '{C_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SHORT_LAT};
        vecs[15] = '{C_REM,    32'd5,        32'd0,        32'd5,        SHORT_LAT};
        vecs[16] = '{C_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SHORT_LAT};
        vecs[17] = '{C_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        SHORT_LAT};
        vecs[18] = '{C_REMU,   32'h80000000, 32'd0,        32'h80000000, SHORT_LAT};

        reset      = 1'b1;
        start_ex   = 1'b0;
        flush_ex   = 1'b0;
        MDUCode_ex = '0;
        A_ex       = '0;
        B_ex       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_result", MDUResult_ex, 32'd0);
        check("reset_done",   {31'd0, done_ex},   32'd0);
        check("reset_busy",   {31'd0, busy_ex},   32'd0);
        check("reset_stall",  {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Table-driven ops
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].code, vecs[i].a, vecs[i].b, res, lat, stalls);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_stalls", i), 32'(stalls), 32'(vecs[i].lat));
        end
        last_exp = vecs[NVEC-1].exp;

        // Flush mid-divide: no done pulse, result held, idle next cycle
        start_ex   = 1'b1;
        MDUCode_ex = C_DIV;
        A_ex       = 32'hFFFFFFF9;
        B_ex       = 32'd2;
        pulses     = 0;
        for (int c = 0; c <= 11; c++) begin
            if (c == 10) flush_ex = 1'b1;
            if (c == 11) begin
                flush_ex = 1'b0;
                start_ex = 1'b0;
            end
            @(negedge clk);
            if (done_ex) pulses++;
            if (c == 5)  check("flush_busy_before", {31'd0, busy_ex}, 32'd1);
            if (c == 11) check("flush_busy_after",  {31'd0, busy_ex}, 32'd0);
            @(posedge clk); #1;
        end
        check("flush_no_done", 32'(pulses), 32'd0);
        check("flush_result_held", MDUResult_ex, last_exp);
        run_op(C_DIVU, 32'd100, 32'd7, res, lat, stalls);
        check("after_flush_result",  res, 32'd14);
        check("after_flush_latency", 32'(lat), 32'(LONG_LAT));

        // Flush and start together: op must not be accepted
        start_ex   = 1'b1;
        flush_ex   = 1'b1;
        MDUCode_ex = C_MUL;
        A_ex       = 32'd3;
        B_ex       = 32'd5;
        @(negedge clk);
        check("flush_start_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        start_ex = 1'b0;
        flush_ex = 1'b0;
        @(negedge clk);
        check("flush_start_busy", {31'd0, busy_ex}, 32'd0);
        @(posedge clk); #1;

        // start_ex held through DONE and the following cycle: one pulse only
        start_ex   = 1'b1;
        MDUCode_ex = C_DIV;
        A_ex       = 32'd100;
        B_ex       = 32'd7;
        pulses     = 0;
        res        = '0;
        for (int c = 0; c < 80; c++) begin
            if (c == 36) start_ex = 1'b0;
            @(negedge clk);
            if (done_ex) begin
                pulses++;
                res = MDUResult_ex;
            end
            if (c == 36) check("held_start_busy", {31'd0, busy_ex}, 32'd0);
            @(posedge clk); #1;
        end
        check("held_start_pulses", 32'(pulses), 32'd1);
        check("held_start_result", res, 32'd14);

        // Reset in the middle of an operation
        start_ex   = 1'b1;
        MDUCode_ex = C_MUL;
        A_ex       = 32'd3;
        B_ex       = 32'd5;
        for (int c = 0; c <= 6; c++) begin
            if (c == 5) begin
                reset    = 1'b1;
                start_ex = 1'b0;
            end
            @(negedge clk);
            if (c == 3) check("midop_busy", {31'd0, busy_ex}, 32'd1);
            if (c == 6) begin
                check("midop_reset_result", MDUResult_ex, 32'd0);
                check("midop_reset_done",   {31'd0, done_ex},   32'd0);
                check("midop_reset_busy",   {31'd0, busy_ex},   32'd0);
                check("midop_reset_stall",  {31'd0, stall_req}, 32'd0);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(C_MUL, 32'd3, 32'd5, res, lat, stalls);
        check("after_reset_result", res, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
